// File: rtl/ppu_pkg.sv
// Shared PPU definitions: OAM word layout, sprite evaluation sizes, FSM encoding.
package ppu_pkg;

  localparam int MAX_SPR     = 8;   // secondary OAM depth
  localparam int OAM_ENTRIES = 64;  // primary OAM entries scanned per line
  localparam int OAM_AW      = 6;   // primary OAM word address width
  localparam int SEC_AW      = 3;   // secondary OAM slot index width
  localparam int CNT_W       = 4;   // sprite count width, holds 0..MAX_SPR

  // OAM word packing: {X[31:24], attr[23:16], tile[15:8], Y[7:0]}
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] attr;
    logic [7:0] tile;
    logic [7:0] y;
  } oam_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } eval_state_t;

  // 9-bit line - Y; bit 8 set means the sprite starts below this line
  function automatic logic [8:0] line_diff(input logic [7:0] line, input logic [7:0] y);
    return {1'b0, line} - {1'b0, y};
  endfunction

endpackage

// File: rtl/ppu_spr_secbuf.sv
// Double-buffered secondary OAM: two banks of MAX_SPR entries (OAM word + row),
// each bank with its own sprite count and sprite-0 flag.
module ppu_spr_secbuf
  import ppu_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,      // clear count/spr0 of w_bank
  input  logic                        we,       // write slot w_idx of w_bank
  input  logic                        w_bank,
  input  logic [SEC_AW-1:0]           w_idx,
  input  logic [31:0]                 w_entry,
  input  logic [3:0]                  w_row,
  input  logic                        w_spr0,
  input  logic                        r_bank,
  input  logic [SEC_AW-1:0]           r_idx,
  output logic [31:0]                 r_entry,
  output logic [3:0]                  r_row,
  output logic [1:0][CNT_W-1:0]       cnt,
  output logic [1:0]                  spr0
);

  logic [1:0][MAX_SPR-1:0][31:0] ent_all;
  logic [1:0][MAX_SPR-1:0][3:0]  row_all;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [MAX_SPR-1:0][31:0] ent_q;
    logic [MAX_SPR-1:0][3:0]  row_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     spr0_q;
    logic                     sel;

    assign sel        = (w_bank == 1'(b));
    assign ent_all[b] = ent_q;
    assign row_all[b] = row_q;
    assign cnt[b]     = cnt_q;
    assign spr0[b]    = spr0_q;

    // Bank storage; count tracks the highest slot written since the last clear
    always_ff @(posedge clk) begin
      if (rst) begin
        ent_q  <= '0;
        row_q  <= '0;
        cnt_q  <= '0;
        spr0_q <= 1'b0;
      end else begin
        if (clr && sel) begin
          cnt_q  <= '0;
          spr0_q <= 1'b0;
        end
        if (we && sel) begin
          ent_q[w_idx] <= w_entry;
          row_q[w_idx] <= w_row;
          cnt_q        <= {1'b0, w_idx} + CNT_W'(1);
          if (w_spr0) spr0_q <= 1'b1;
        end
      end
    end
  end

  assign r_entry = ent_all[r_bank][r_idx];
  assign r_row   = row_all[r_bank][r_idx];

endmodule

// File: rtl/ppu_spr_eval.sv
// Per-scanline sprite evaluation: scans 64 OAM entries, keeps up to 8 hits in
// the write bank of secondary OAM, publishes the finished bank on line start.
module ppu_spr_eval
  import ppu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_line_start,
  input  logic [7:0]        i_line,
  input  logic              i_spr_16,
  input  logic              i_render_en,
  input  logic              i_frame_start,
  output logic [OAM_AW-1:0] o_oam_addr,
  input  logic [31:0]       i_oam_rdata,
  input  logic [SEC_AW-1:0] i_sec_idx,
  output logic [31:0]       o_sec_entry,
  output logic [3:0]        o_sec_row,
  output logic [CNT_W-1:0]  o_spr_cnt,
  output logic              o_spr0_in,
  output logic              o_spr_ovfl,
  output logic              o_busy,
  output logic              o_done
);

  eval_state_t       state;
  logic [7:0]        line_q;
  logic              h16_q;
  logic [CNT_W-1:0]  hit_cnt;
  logic              wr_bank, rd_bank, complete;

  oam_entry_t        oam_ent;
  logic [8:0]        diff;
  logic [7:0]        height;
  logic              cmp_en, hit, ovf_hit, set_ovfl, last_addr;
  logic              wb_next, sec_bank, sec_clr, sec_we, sec_spr0;
  logic [1:0][CNT_W-1:0] bank_cnt;
  logic [1:0]        bank_spr0;

  // Read data always belongs to the address presented one cycle earlier,
  // so address 0 in SCAN has nothing to compare yet.
  assign oam_ent   = oam_entry_t'(i_oam_rdata);
  assign diff      = line_diff(line_q, oam_ent.y);
  assign height    = h16_q ? 8'd16 : 8'd8;
  assign cmp_en    = (state == ST_SCAN && o_oam_addr != '0) || state == ST_DRAIN;
  assign hit       = cmp_en && !diff[8] && (diff[7:0] < height);
  assign ovf_hit   = hit && (hit_cnt == CNT_W'(MAX_SPR));
  assign set_ovfl  = ovf_hit && !i_line_start;
  assign last_addr = (o_oam_addr == OAM_AW'(OAM_ENTRIES - 1));

  // A line start retargets the buffer to the bank that will be written next;
  // a compare in the same cycle is part of the discarded scan.
  assign wb_next   = (i_line_start && complete) ? ~wr_bank : wr_bank;
  assign sec_bank  = i_line_start ? wb_next : wr_bank;
  assign sec_clr   = i_line_start && i_render_en;
  assign sec_we    = hit && !ovf_hit && !i_line_start;
  assign sec_spr0  = (state == ST_SCAN) && (o_oam_addr == OAM_AW'(1));

  ppu_spr_secbuf u_secbuf (
    .clk     (i_clk),
    .rst     (i_rst),
    .clr     (sec_clr),
    .we      (sec_we),
    .w_bank  (sec_bank),
    .w_idx   (hit_cnt[SEC_AW-1:0]),
    .w_entry (i_oam_rdata),
    .w_row   (diff[3:0]),
    .w_spr0  (sec_spr0),
    .r_bank  (rd_bank),
    .r_idx   (i_sec_idx),
    .r_entry (o_sec_entry),
    .r_row   (o_sec_row),
    .cnt     (bank_cnt),
    .spr0    (bank_spr0)
  );

  // Evaluation FSM: publish/start on line start, scan address counter, finish
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      line_q     <= '0;
      h16_q      <= 1'b0;
      hit_cnt    <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b1;
      complete   <= 1'b0;
      o_oam_addr <= '0;
      o_spr_cnt  <= '0;
      o_spr0_in  <= 1'b0;
      o_spr_ovfl <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (set_ovfl)           o_spr_ovfl <= 1'b1;
      else if (i_frame_start) o_spr_ovfl <= 1'b0;

      if (i_line_start) begin
        if (complete) begin
          rd_bank   <= wr_bank;
          wr_bank   <= ~wr_bank;
          o_spr_cnt <= bank_cnt[wr_bank];
          o_spr0_in <= bank_spr0[wr_bank];
        end else begin
          o_spr_cnt <= '0;
          o_spr0_in <= 1'b0;
        end
        complete <= 1'b0;
        if (i_render_en) begin
          line_q     <= i_line;
          h16_q      <= i_spr_16;
          hit_cnt    <= '0;
          o_oam_addr <= '0;
          state      <= ST_SCAN;
          o_busy     <= 1'b1;
        end else begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      end else begin
        case (state)
          ST_SCAN, ST_DRAIN: begin
            if (hit && !ovf_hit) hit_cnt <= hit_cnt + CNT_W'(1);
            if (ovf_hit || state == ST_DRAIN) begin
              state    <= ST_IDLE;
              o_busy   <= 1'b0;
              o_done   <= 1'b1;
              complete <= 1'b1;
            end else if (last_addr) begin
              state <= ST_DRAIN;
            end else begin
              o_oam_addr <= o_oam_addr + OAM_AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ppu_spr_eval.sv
// Scoreboard bench for ppu_spr_eval: stimulus queues expected publishes, done
// pulses and timed signal probes; a monitor compares them at each negedge.
module tb_ppu_spr_eval;
  import ppu_pkg::*;

  logic        clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst, line_start, spr_16, render_en, frame_start;
  logic [7:0]  line;
  logic [5:0]  oam_addr;
  logic [31:0] oam_rdata, sec_entry;
  logic [2:0]  sec_idx;
  logic [3:0]  sec_row, spr_cnt;
  logic        spr0_in, spr_ovfl, busy, done;

  logic [31:0] oam [64];
  always @(posedge clk) oam_rdata <= oam[oam_addr];

  ppu_spr_eval dut (
    .i_clk(clk), .i_rst(rst), .i_line_start(line_start), .i_line(line),
    .i_spr_16(spr_16), .i_render_en(render_en), .i_frame_start(frame_start),
    .o_oam_addr(oam_addr), .i_oam_rdata(oam_rdata), .i_sec_idx(sec_idx),
    .o_sec_entry(sec_entry), .o_sec_row(sec_row), .o_spr_cnt(spr_cnt),
    .o_spr0_in(spr0_in), .o_spr_ovfl(spr_ovfl), .o_busy(busy), .o_done(done)
  );

  typedef struct { int cyc; int id; logic [31:0] val; } probe_t;
  typedef struct { int cyc; bit ovfl; } done_t;
  typedef struct { int n; bit s0; logic [31:0] ent[8]; logic [3:0] row[8]; } pub_t;

  localparam int P_ADDR = 0, P_BUSY = 1, P_OVFL = 2, P_CNT = 3,
                 P_SPR0 = 4, P_DONE = 5, P_ENTRY = 6, P_ROW = 7;
  string pname [8] = '{"oam_addr", "busy", "spr_ovfl", "spr_cnt",
                       "spr0_in", "done", "sec_entry", "sec_row"};

  probe_t probes[$];
  done_t  done_q[$];
  pub_t   pub_q[$];
  int     exp_idx[$];
  int     cyc = 0;
  int     checks = 0, errors = 0;
  logic   ls_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ls_seen <= line_start;

  function automatic logic [31:0] mk(input int i, input logic [7:0] y);
    return {8'(i * 2 + 1), 8'(i ^ 90), 8'(i + 100), y};
  endfunction

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] probe_val(input int id);
    case (id)
      P_ADDR:  return 32'(oam_addr);
      P_BUSY:  return 32'(busy);
      P_OVFL:  return 32'(spr_ovfl);
      P_CNT:   return 32'(spr_cnt);
      P_SPR0:  return 32'(spr0_in);
      P_DONE:  return 32'(done);
      P_ENTRY: return sec_entry;
      default: return 32'(sec_row);
    endcase
  endfunction

  // Monitor: timed probes, done pulses and the publish after each line start
  initial begin
    done_t d;
    pub_t  p;
    sec_idx = '0;
    forever begin
      @(negedge clk);
      for (int i = probes.size() - 1; i >= 0; i--)
        if (probes[i].cyc == cyc) begin
          chk(pname[probes[i].id], probe_val(probes[i].id), probes[i].val);
          probes.delete(i);
        end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: o_done=1 at cycle %0d, none expected", cyc);
        end else begin
          d = done_q.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_ovfl", 32'(spr_ovfl), 32'(d.ovfl));
        end
      end
      if (ls_seen) begin
        if (pub_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL publish_unexpected at cycle %0d", cyc);
        end else begin
          p = pub_q.pop_front();
          chk("pub_cnt", 32'(spr_cnt), p.n);
          chk("pub_spr0", 32'(spr0_in), 32'(p.s0));
          for (int k = 0; k < p.n; k++) begin
            sec_idx = 3'(k);
            #1;
            chk($sformatf("pub_entry%0d", k), sec_entry, p.ent[k]);
            chk($sformatf("pub_row%0d", k), 32'(sec_row), 32'(p.row[k]));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic pr(input int c, input int id, input logic [31:0] v);
    probe_t q;
    q.cyc = c; q.id = id; q.val = v;
    probes.push_back(q);
  endtask

  task automatic exp_pub(input int n, input bit s0, input logic [3:0] row);
    pub_t p;
    p.n = n; p.s0 = s0;
    for (int k = 0; k < 8; k++) begin p.ent[k] = '0; p.row[k] = '0; end
    for (int k = 0; k < n; k++) begin p.ent[k] = oam[exp_idx[k]]; p.row[k] = row; end
    pub_q.push_back(p);
  endtask

  task automatic do_line(input logic [7:0] ln, input bit s16, input bit ren,
                         input int done_off, input bit done_ovfl, output int t);
    done_t d;
    line = ln; spr_16 = s16; render_en = ren; line_start = 1'b1;
    t = cyc;
    if (done_off > 0) begin d.cyc = t + done_off; d.ovfl = done_ovfl; done_q.push_back(d); end
    step();
    line_start = 1'b0;
  endtask

  task automatic pulse_frame(output int t);
    frame_start = 1'b1; t = cyc; step(); frame_start = 1'b0;
  endtask

  initial begin
    int t, t2, tf;
    rst = 1'b1; line_start = 1'b0; spr_16 = 1'b0; render_en = 1'b0;
    frame_start = 1'b0; line = '0;
    for (int i = 0; i < 64; i++) oam[i] = mk(i, 8'hF0);
    repeat (3) step();
    rst = 1'b0;
    for (int id = 0; id < 8; id++) pr(cyc, id, '0);

    // rendering off: no scan, no address activity
    exp_pub(0, 0, 0);
    do_line(8'h10, 0, 0, 0, 0, t);
    for (int k = 1; k <= 5; k++) begin pr(t + k, P_ADDR, 0); pr(t + k, P_BUSY, 0); end
    wait_until(t + 8);

    // all Y = F0: full-length scan, timing of address/busy/done
    exp_pub(0, 0, 0);
    do_line(8'h10, 0, 1, 66, 0, t);
    pr(t + 1, P_ADDR, 0);  pr(t + 1, P_BUSY, 1);
    pr(t + 64, P_ADDR, 63); pr(t + 65, P_BUSY, 1);
    pr(t + 66, P_BUSY, 0); pr(t + 66, P_OVFL, 0);
    wait_until(t + 70);

    // sprites 0, 5, 63 at Y=0x20
    oam[0] = mk(0, 8'h20); oam[5] = mk(5, 8'h20); oam[63] = mk(63, 8'h20);
    exp_pub(0, 0, 0);
    do_line(8'h27, 0, 1, 66, 0, t);
    wait_until(t + 70);
    exp_idx = '{0, 5, 63};
    exp_pub(3, 1, 4'd7);
    do_line(8'h28, 0, 1, 66, 0, t);
    wait_until(t + 70);
    exp_pub(0, 0, 0);
    do_line(8'h28, 1, 1, 66, 0, t);
    wait_until(t + 70);
    exp_pub(3, 1, 4'd8);
    do_line(8'h10, 0, 1, 66, 0, t);
    wait_until(t + 70);

    // ten sprites on line 0x40: ninth hit is entry 40, compared at T+42
    oam[0] = mk(0, 8'hF0); oam[5] = mk(5, 8'hF0); oam[63] = mk(63, 8'hF0);
    exp_idx = '{3, 7, 9, 12, 20, 25, 30, 33, 40, 50};
    for (int k = 0; k < 10; k++) oam[exp_idx[k]] = mk(exp_idx[k], 8'h40);
    exp_pub(0, 0, 0);
    do_line(8'h40, 0, 1, 43, 1, t);
    pr(t + 42, P_ADDR, 41); pr(t + 42, P_OVFL, 0);
    pr(t + 43, P_OVFL, 1);  pr(t + 43, P_BUSY, 0);
    wait_until(t + 50);
    exp_pub(8, 0, 4'd0);
    do_line(8'h10, 0, 1, 66, 1, t);
    pr(t + 1, P_OVFL, 1);
    wait_until(t + 70);
    pulse_frame(tf);
    pr(tf + 1, P_OVFL, 0);
    wait_until(tf + 3);

    // overflow set and frame clear in the same cycle: set wins
    exp_pub(0, 0, 0);
    do_line(8'h40, 0, 1, 43, 1, t);
    wait_until(t + 42);
    pulse_frame(tf);
    pr(t + 43, P_OVFL, 1);
    wait_until(t + 50);
    pulse_frame(tf);
    pr(tf + 1, P_OVFL, 0);
    wait_until(tf + 3);

    // abort mid-scan, restart on line 0x44 with eight sprites left
    oam[40] = mk(40, 8'hF0); oam[50] = mk(50, 8'hF0);
    exp_pub(8, 0, 4'd0);
    do_line(8'h10, 0, 1, 0, 0, t);
    wait_until(t + 30);
    pr(t + 30, P_ADDR, 29);
    exp_pub(0, 0, 0);
    do_line(8'h44, 0, 1, 66, 0, t2);
    pr(t + 31, P_ADDR, 0); pr(t + 31, P_BUSY, 1);
    wait_until(t + 100);

    // publish the restarted result, then reset in the middle of the next scan
    exp_pub(8, 0, 4'd4);
    do_line(8'h40, 0, 1, 0, 0, t);
    wait_until(t + 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int id = 0; id < 8; id++) pr(t + 21, id, '0);
    wait_until(t + 25);

    foreach (done_q[i]) begin
      checks++; errors++;
      $display("FAIL done_missing: expected at cycle %0d, got none", done_q[i].cyc);
    end
    foreach (pub_q[i]) begin
      checks++; errors++;
      $display("FAIL publish_missing: count %0d never checked", pub_q[i].n);
    end
    foreach (probes[i]) begin
      checks++; errors++;
      $display("FAIL probe_missing: %s at cycle %0d never sampled", pname[probes[i].id], probes[i].cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_spr_eval.md
# ppu_spr_eval

Per-scanline sprite evaluation stage, directly upstream of `ppu_rde` in the PPU clock domain. On each line-start strobe it scans all 64 OAM entries through the PPU-side OAM read port (64x32 view) and selects up to 8 sprites that intersect the requested scanline. Results go into a double-buffered secondary OAM, so `ppu_rde` reads the published list for the current line while the next line is evaluated. It also produces the sprite-overflow flag that `ppu_cfg` reports in PPUSTATUS.

## Interface
- MAX_SPR, 8, secondary OAM depth (sprites per line)
- OAM_ENTRIES, 64, primary OAM entries scanned
- i_clk  in  1  PPU clock (`i_ppu_clk` at top level)
- i_rst  in  1  reset, synchronous, active-high
- i_line_start  in  1  one-cycle strobe: publish last result, start evaluating `i_line`
- i_line  in  8  scanline to evaluate, sampled on `i_line_start`
- i_spr_16  in  1  PPUCTRL bit 5 (8x16 sprites), sampled on `i_line_start`
- i_render_en  in  1  PPUMASK bit 3 | bit 4, sampled on `i_line_start`
- i_frame_start  in  1  one-cycle strobe, clears sticky overflow
- o_oam_addr  out  6  OAM word address; read data arrives 1 cycle later
- i_oam_rdata  in  32  {X[31:24], attr[23:16], tile[15:8], Y[7:0]}
- i_sec_idx  in  3  published-list read index
- o_sec_entry  out  32  published entry at `i_sec_idx`, same packing as OAM (combinational read)
- o_sec_row  out  4  row within sprite for that entry (line − Y), before any flip
- o_spr_cnt  out  4  published sprite count, 0..8
- o_spr0_in  out  1  published list slot 0 is OAM sprite 0
- o_spr_ovfl  out  1  sticky overflow flag
- o_busy  out  1  evaluation in progress
- o_done  out  1  one-cycle pulse, evaluation finished

## Operation
- Reset: every output 0, including `o_oam_addr`, count, flags and both banks. Write bank = 0; no complete result.
- FSM states: IDLE, SCAN, DRAIN.
- IDLE + `i_line_start`:
  - Publish first. If a complete result exists, swap banks and load that bank's count and sprite-0 flag. If not, publish count 0 and `o_spr0_in` 0.
  - Then, if `i_render_en` = 1: latch line and height (8 or 16), clear write-bank count, address ← 0, go to SCAN.
  - If `i_render_en` = 0: no scan, and the next publish is empty.
- SCAN: present address n (0..63) while comparing entry n−1 from the previous cycle. After address 63 go to DRAIN, which compares entry 63 only.
- Hit test: 9-bit diff = {0,line} − {0,Y}. Hit when diff[8] = 0 and diff[7:0] < height. Row = diff[3:0].
- Hits 1..8 are written in OAM order to write-bank slots 0..7, each with its row; count increments. A hit on entry 0 sets the write bank's sprite-0 flag.
- 9th hit: set `o_spr_ovfl`, stop scanning at once, go IDLE, pulse `o_done`, mark the result complete.
- Normal end (DRAIN) → IDLE, pulse `o_done`, mark complete.
- `i_line_start` during SCAN/DRAIN:
  - Abort; the partial result is discarded.
  - Publish an empty list.
  - Restart the scan with the new line and mode from address 0 on the next cycle.
- `o_spr_ovfl` stays set until `i_frame_start`. If set and clear happen in the same cycle, set wins.
- Published outputs change only on `i_line_start`.

## Timing
- `i_line_start` at cycle T:
  - Published outputs valid from T+1.
  - `o_oam_addr` = 0 at T+1, = 63 at T+64.
  - Last compare (DRAIN) at T+65.
  - `o_done` high at T+66.
  - `o_busy` high T+1..T+65.
- Overflow exit: `o_done` and `o_spr_ovfl` rise 1 cycle after the compare cycle that saw the 9th hit.
- Minimum line-start spacing for a complete result: 66 cycles. The real line pitch is 341.
- `o_sec_entry` / `o_sec_row` follow `i_sec_idx` combinationally. Reads with index ≥ count return stale slot data; the consumer gates them with `o_spr_cnt`.

## Structure
- Shared package `ppu_pkg`:
  - OAM field bit ranges (Y/tile/attr/X).
  - Widths MAX_SPR and OAM_ENTRIES.
  - FSM state encoding.
- One sub-module `ppu_spr_secbuf`: 2 banks x 8 x (32+4) registers, write port, combinational read port, and per-bank count and sprite-0 flag.
- FSM, address counter and hit compare stay in the top.

## Test plan
- OAM all Y = 0xF0, line 0x10, 8x8: `o_done` at T+66, `o_spr_cnt` = 0 after next line_start, `o_spr_ovfl` = 0.
- Sprites 0, 5, 63 at Y = 0x20; line 0x27, 8x8: next publish gives count 3, `o_spr0_in` = 1, slots 0/1/2 = entries 0/5/63, rows = 7.
- Same OAM, line 0x28: count 0 with 8x8; count 3 with rows 8 when `i_spr_16` = 1.
- 10 sprites at Y = 0x40, line 0x40: slots 0..7 = first 8 hits. `o_spr_ovfl` rises 1 cycle after the 9th-hit compare (before address 63), stays set through later lines, clears on `i_frame_start`. Set + clear in the same cycle keeps it 1.
- `i_line_start` at T+30 mid-scan: publish count 0, `o_oam_addr` restarts at 0 at T+31, `o_done` at T+96.
- `i_render_en` = 0: no OAM address activity, `o_busy` stays 0. Assert `i_rst` mid-scan: every output 0 on the next cycle.
